// File: rtl/pc_stack_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_stack_unit_if : fetch-side control/status bundle for pc_stack_unit     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface pc_stack_unit_if #(
   parameter int ADDR_W      = 6,
   parameter int OFF_W       = 8,
   parameter int STACK_DEPTH = 4
) ();
   localparam int c_sp_w = $clog2(STACK_DEPTH + 1);

   logic [ADDR_W-1:0]  A;
   logic [OFF_W/2-1:0] SA;
   logic [OFF_W/2-1:0] SB;
   logic [2:0]         PS;
   logic               stall;
   logic               err_clr;
   logic [ADDR_W-1:0]  PC;
   logic [c_sp_w-1:0]  sp;
   logic               full;
   logic               empty;
   logic               ovf;
   logic               unf;

   modport master (
      output A, SA, SB, PS, stall, err_clr,
      input  PC, sp, full, empty, ovf, unf
   );

   modport slave (
      input  A, SA, SB, PS, stall, err_clr,
      output PC, sp, full, empty, ovf, unf
   );
endinterface
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_stack_unit : program counter with return-address stack (LIFO).        |
// | Stack, sp, full/empty and ovf exist only when PC_STACK_EN is defined.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pc_stack_unit #(
   parameter int ADDR_W      = 6,
   parameter int OFF_W       = 8,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_VEC   = 0
) (
   input  wire logic      clk_main,
   input  wire logic      reset,
   pc_stack_unit_if.slave bus
);
   localparam int c_sp_w  = $clog2(STACK_DEPTH + 1);
   localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] c_ps_inc  = 3'b001;
   localparam logic [2:0] c_ps_rel  = 3'b010;
   localparam logic [2:0] c_ps_idx  = 3'b011;
   localparam logic [2:0] c_ps_abs  = 3'b100;
   localparam logic [2:0] c_ps_call = 3'b101;
   localparam logic [2:0] c_ps_ret  = 3'b110;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] off_ext;
   logic [OFF_W-1:0]  off_raw;
   logic              unf_q, unf_d;

   assign off_raw = {bus.SA, bus.SB};
   // Signed size cast sign-extends a narrow offset and truncates a wide one.
   assign off_ext = ADDR_W'($signed(off_raw));
   assign pc_inc  = pc_q + ADDR_W'(1);

`ifdef PC_STACK_EN
   localparam logic [c_sp_w-1:0] c_sp_full = c_sp_w'(STACK_DEPTH);

   logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
   logic [c_sp_w-1:0]  sp_q, sp_d;
   logic               ovf_q, ovf_d;
   logic               push_en;
   logic [c_idx_w-1:0] push_idx;
   logic [c_idx_w-1:0] top_idx;

   assign push_idx = c_idx_w'(sp_q);
   assign top_idx  = c_idx_w'(sp_q - 1'b1);
`endif

   always_comb begin
      pc_d  = pc_q;
      unf_d = unf_q & ~bus.err_clr;
`ifdef PC_STACK_EN
      sp_d    = sp_q;
      ovf_d   = ovf_q & ~bus.err_clr;
      push_en = 1'b0;
`endif
      if (!bus.stall) begin
         case (bus.PS)
            c_ps_inc: pc_d = pc_inc;
            c_ps_rel: pc_d = pc_inc + off_ext;
            c_ps_idx: pc_d = pc_q + bus.A;
            c_ps_abs: pc_d = bus.A;
            c_ps_call: begin
               pc_d = bus.A;
`ifdef PC_STACK_EN
               if (sp_q == c_sp_full) begin
                  ovf_d = 1'b1;
               end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + 1'b1;
               end
`endif
            end
            c_ps_ret: begin
`ifdef PC_STACK_EN
               if (sp_q == '0) begin
                  unf_d = 1'b1;
               end else begin
                  pc_d = stack_q[top_idx];
                  sp_d = sp_q - 1'b1;
               end
`else
               unf_d = 1'b1;
`endif
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         pc_q  <= ADDR_W'(RESET_VEC);
         unf_q <= 1'b0;
`ifdef PC_STACK_EN
         sp_q  <= '0;
         ovf_q <= 1'b0;
`endif
      end else begin
         pc_q  <= pc_d;
         unf_q <= unf_d;
`ifdef PC_STACK_EN
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
`endif
      end
   end

`ifdef PC_STACK_EN
   // Entries are only meaningful below sp, so the storage needs no reset.
   always_ff @(posedge clk_main) begin
      if (push_en) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign bus.sp    = sp_q;
   assign bus.full  = (sp_q == c_sp_full);
   assign bus.empty = (sp_q == '0);
   assign bus.ovf   = ovf_q;
`else
   assign bus.sp    = '0;
   assign bus.full  = 1'b0;
   assign bus.empty = 1'b1;
   assign bus.ovf   = 1'b0;
`endif

   assign bus.PC  = pc_q;
   assign bus.unf = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_stack_unit : directed self-checking bench for pc_stack_unit.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pc_stack_unit;
`ifdef PC_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic clk_main = 1'b0;
   logic reset    = 1'b0;
   int   n_cmp    = 0;
   int   n_fail   = 0;

   pc_stack_unit_if #(.ADDR_W(6), .OFF_W(8), .STACK_DEPTH(4)) bus ();

   pc_stack_unit #(
      .ADDR_W(6), .OFF_W(8), .STACK_DEPTH(4), .RESET_VEC(0)
   ) dut (
      .clk_main (clk_main),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 clk_main = ~clk_main;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] ps, input logic [5:0] a,
                       input logic [3:0] sa, input logic [3:0] sb,
                       input logic st, input logic clr);
      bus.PS      = ps;
      bus.A       = a;
      bus.SA      = sa;
      bus.SB      = sb;
      bus.stall   = st;
      bus.err_clr = clr;
      @(posedge clk_main);
      #1;
   endtask

   initial begin
      bus.PS = 3'b000; bus.A = '0; bus.SA = '0; bus.SB = '0;
      bus.stall = 1'b0; bus.err_clr = 1'b0;
      @(posedge clk_main);
      #1;
      chk("rst_pc",    bus.PC,    0);
      chk("rst_sp",    bus.sp,    0);
      chk("rst_full",  bus.full,  0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_ovf",   bus.ovf,   0);
      chk("rst_unf",   bus.unf,   0);
      reset = 1'b1;

      step(3'b001, 0, 0, 0, 0, 0); chk("inc1", bus.PC, 1);
      step(3'b001, 0, 0, 0, 0, 0); chk("inc2", bus.PC, 2);
      step(3'b001, 0, 0, 0, 0, 0); chk("inc3", bus.PC, 3);

      step(3'b100, 2, 0, 0, 0, 0);       chk("abs2",    bus.PC, 2);
      step(3'b010, 0, 4'hF, 4'hC, 0, 0); chk("rel_neg", bus.PC, 63);
      step(3'b010, 0, 4'h0, 4'h5, 0, 0); chk("rel_pos", bus.PC, 5);

      step(3'b101, 20, 0, 0, 0, 0);
      chk("call1_pc", bus.PC, 20); chk("call1_sp", bus.sp, STK ? 1 : 0);
      step(3'b101, 40, 0, 0, 0, 0);
      chk("call2_pc", bus.PC, 40); chk("call2_sp", bus.sp, STK ? 2 : 0);
      step(3'b110, 0, 0, 0, 0, 0);
      chk("ret1_pc", bus.PC, STK ? 21 : 40); chk("ret1_unf", bus.unf, STK ? 0 : 1);
      step(3'b110, 0, 0, 0, 0, 0);
      chk("ret2_pc", bus.PC, STK ? 6 : 40);
      chk("ret2_sp", bus.sp, 0); chk("ret2_empty", bus.empty, 1);
      step(3'b000, 0, 0, 0, 0, 1); chk("clr_unf_a", bus.unf, 0);

      step(3'b100, 6, 0, 0, 0, 0);  chk("abs6",  bus.PC, 6);
      step(3'b011, 60, 0, 0, 0, 0); chk("idx",   bus.PC, 2);
      step(3'b111, 33, 0, 0, 0, 0); chk("rsvd",  bus.PC, 2);

      step(3'b100, 0, 0, 0, 0, 0);
      step(3'b101, 10, 0, 0, 0, 0);
      step(3'b101, 10, 0, 0, 0, 0);
      step(3'b101, 10, 0, 0, 0, 0);
      chk("ovf_c3_full", bus.full, 0);
      step(3'b101, 10, 0, 0, 0, 0);
      chk("ovf_c4_full", bus.full, STK ? 1 : 0);
      chk("ovf_c4_ovf",  bus.ovf,  0);
      step(3'b101, 10, 0, 0, 0, 0);
      chk("ovf_c5_pc",  bus.PC,  10);
      chk("ovf_c5_sp",  bus.sp,  STK ? 4 : 0);
      chk("ovf_c5_ovf", bus.ovf, STK ? 1 : 0);
      step(3'b000, 0, 0, 0, 0, 1);
      chk("ovf_clr", bus.ovf, 0); chk("ovf_clr_sp", bus.sp, STK ? 4 : 0);

      step(3'b110, 0, 0, 0, 0, 0);
      chk("pop4_pc", bus.PC, STK ? 11 : 10); chk("pop4_sp", bus.sp, STK ? 3 : 0);
      step(3'b110, 0, 0, 0, 0, 0);
      step(3'b110, 0, 0, 0, 0, 0);
      step(3'b110, 0, 0, 0, 0, 0);
      chk("pop1_pc", bus.PC, STK ? 1 : 10); chk("pop1_empty", bus.empty, 1);
      step(3'b000, 0, 0, 0, 0, 1); chk("clr_unf_b", bus.unf, 0);

      step(3'b100, 7, 0, 0, 0, 0);
      step(3'b110, 0, 0, 0, 0, 0);
      chk("unf_pc", bus.PC, 7); chk("unf_set", bus.unf, 1);
      step(3'b000, 0, 0, 0, 0, 1); chk("unf_clr", bus.unf, 0);
      step(3'b110, 0, 0, 0, 0, 1); chk("unf_set_wins", bus.unf, 1);
      step(3'b000, 0, 0, 0, 0, 1); chk("unf_clr2", bus.unf, 0);

      step(3'b001, 0, 0, 0, 1, 0); chk("stall1", bus.PC, 7);
      step(3'b001, 0, 0, 0, 1, 0); chk("stall2", bus.PC, 7);
      step(3'b110, 0, 0, 0, 1, 0); chk("stall_noflag", bus.unf, 0);
      step(3'b101, 9, 0, 0, 1, 0);
      chk("stall_call_pc", bus.PC, 7); chk("stall_call_sp", bus.sp, 0);

      step(3'b101, 50, 0, 0, 0, 0); chk("b2b_call", bus.PC, 50);
      step(3'b110, 0, 0, 0, 0, 0);  chk("b2b_ret",  bus.PC, STK ? 8 : 50);

      step(3'b101, 20, 0, 0, 0, 0);
      step(3'b101, 33, 0, 0, 0, 0);
      chk("pre_rst_pc", bus.PC, 33); chk("pre_rst_sp", bus.sp, STK ? 2 : 0);
      bus.PS = 3'b110;
      #1 reset = 1'b0;
      #1;
      chk("arst_pc",    bus.PC,    0);
      chk("arst_sp",    bus.sp,    0);
      chk("arst_empty", bus.empty, 1);
      chk("arst_full",  bus.full,  0);
      @(posedge clk_main);
      #1;
      chk("arst_hold_pc", bus.PC, 0);
      reset = 1'b1;
      step(3'b001, 0, 0, 0, 0, 0); chk("post_rst_inc", bus.PC, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter with a hardware return-address stack. Sits in the fetch stage, replaces the fixed 6-bit PC, and drives the instruction-memory address. It supports:
- hold, increment, signed relative branch, indexed jump and absolute jump;
- subroutine call/return through a LIFO of configurable depth, with sticky overflow and underflow error flags.

## Interface
Parameters:
- ADDR_W, 6, PC and address width in bits (4..16).
- OFF_W, 8, relative offset width; must equal width(SA)+width(SB).
- STACK_DEPTH, 4, return-stack entries (2..16, power of two not required).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk_main  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- A  in  ADDR_W  jump operand / call target.
- SA  in  OFF_W/2  offset high half.
- SB  in  OFF_W/2  offset low half.
- PS  in  3  PC select.
- stall  in  1  freeze PC and stack when 1.
- err_clr  in  1  clears sticky flags.
- PC  out  ADDR_W  current program counter.
- sp  out  $clog2(STACK_DEPTH+1)  occupied stack entries.
- full  out  1  sp == STACK_DEPTH.
- empty  out  1  sp == 0.
- ovf  out  1  sticky: call issued while full.
- unf  out  1  sticky: return issued while empty.

## Operation
Offset definition:
- off = {SA,SB}, treated as two's-complement.
- Sign-extended to ADDR_W, or truncated to ADDR_W if OFF_W > ADDR_W.

PS decode:
- 000 hold: PC <= PC.
- 001 increment: PC <= PC+1.
- 010 relative branch: PC <= PC+off+1.
- 011 indexed jump: PC <= PC+A.
- 100 absolute jump: PC <= A.
- 101 call:
  - Push PC+1, then PC <= A.
  - If full: push discarded, stack and sp unchanged, PC <= A still, ovf set.
- 110 return:
  - Pop: PC <= top entry, sp decrements.
  - If empty: PC <= PC, unf set.
- 111 reserved: behaves as hold.

Arithmetic and flags:
- All PC arithmetic is modulo 2^ADDR_W; carries are dropped, giving silent wrap-around.
- stall=1 overrides PS: PC, stack and sp hold, and no flag is set.
- err_clr=1 clears ovf and unf on the next edge. If a new error occurs in the same cycle, the set wins.
- full and empty are combinational from sp.
- Stack contents are not readable externally.

## Timing
- Single cycle: every PS action takes effect at the rising clk_main edge after it is presented, and PC updates that edge.
- Call followed immediately by return in back-to-back cycles returns to call-site+1 with no bubble.
- Reset asserted (reset=0), asynchronously and immediately, regardless of clock:
  - PC=RESET_VEC, sp=0, full=0, empty=1, ovf=0, unf=0.
  - Stack RAM contents are don't-care.
- Reset asserted mid-call or mid-return discards the operation.
- Deassertion is synchronised externally; first update is at the first edge with reset=1.
- Inputs are sampled only at the edge; no handshake beyond stall.

## Configuration
- Macro: PC_STACK_EN.
- Defined: return stack, sp, full, empty, ovf and unf are implemented as above.
- Undefined:
  - No stack storage.
  - PS=101 behaves as absolute jump (PC <= A).
  - PS=110 behaves as hold and sets unf.
  - sp ties to 0, full to 0, empty to 1, ovf to 0.

## Test plan
All scenarios use defaults ADDR_W=6, OFF_W=8, STACK_DEPTH=4, RESET_VEC=0, with PC_STACK_EN defined.
- Reset then increment: release reset, PS=001 for 3 cycles -> PC=0,1,2,3.
- Negative branch with wrap: PC=2, SA=4'hF, SB=4'hC (off=-4), PS=010 -> PC=63 (2-4+1 mod 64).
- Nested calls and returns:
  - From PC=5, call A=20, then from PC=20 call A=40 -> sp=2, PC=40.
  - Return -> PC=21; return -> PC=6; sp=0, empty=1.
- Overflow:
  - 5 consecutive calls to A=10 starting at PC=0 -> after 4th call full=1.
  - 5th call: PC=10, sp=4, ovf=1.
  - err_clr pulse -> ovf=0, sp still 4.
- Underflow and stall:
  - Empty stack, PC=7, PS=110 -> PC=7, unf=1.
  - stall=1 with PS=001 for 2 cycles -> PC stays 7.
- Async reset mid-sequence: assert reset between edges with PC=33, sp=2 -> PC=0, sp=0, empty=1 immediately, before the next edge.
